// File: rtl/multiplier_128b_reg_if.sv
// multiplier_128b_reg_if: operand/product bundle for multiplier_128b_reg
// MULTIPLIER_128B_REG_VALID_EN adds the oValid flag.
interface multiplier_128b_reg_if #(parameter int WIDTH = 128);
  logic iEn;
  logic iClr;
  logic [WIDTH-1:0] iData0;
  logic [WIDTH-1:0] iData1;
  logic [2*WIDTH-1:0] oData;
`ifdef MULTIPLIER_128B_REG_VALID_EN
  logic oValid;
  modport master(output iEn, iClr, iData0, iData1, input oData, oValid);
  modport slave(input iEn, iClr, iData0, iData1, output oData, oValid);
`else
  modport master(output iEn, iClr, iData0, iData1, input oData);
  modport slave(input iEn, iClr, iData0, iData1, output oData);
`endif
endinterface

// File: rtl/multiplier_128b_reg.sv
// multiplier_128b_reg: 7-stage pipelined unsigned WIDTH x WIDTH multiplier
// MULTIPLIER_128B_REG_VALID_EN adds a valid chain driving oValid.
module multiplier_128b_reg #(
  parameter int WIDTH = 128,
  parameter int LIMB = 32
) (
  input logic iClk,
  input logic iRst,
  multiplier_128b_reg_if.slave bus
);
  localparam int N = WIDTH / LIMB;
  localparam int PW = 2 * LIMB;
  localparam int W2 = 2 * WIDTH;
  logic [WIDTH-1:0] a, b;
  logic [PW-1:0] pp [N*N];
  logic [PW-1:0] ppNext [N*N];
  logic [W2-1:0] row [N];
  logic [W2-1:0] rowNext [N];
  logic [W2-1:0] p0, p1, p0Next, p1Next;
  logic [W2-1:0] sv, cv, sum, out;
  logic flush;
  assign flush = iRst || bus.iClr;
  assign bus.oData = out;
  always_comb begin
    ppNext = '{default: '0};
    rowNext = '{default: '0};
    p0Next = '0;
    p1Next = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        ppNext[i*N+j] = PW'(a[i*LIMB +: LIMB]) * PW'(b[j*LIMB +: LIMB]);
    // Rows carry their full alignment so later stages are plain additions.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        rowNext[i] = rowNext[i] + (W2'(pp[i*N+j]) << ((i + j) * LIMB));
    for (int i = 0; i < N; i++)
      if (i % 2 == 0) p0Next = p0Next + row[i];
      else p1Next = p1Next + row[i];
  end
  always_ff @(posedge iClk)
    if (flush) begin
      a <= '0;
      b <= '0;
      pp <= '{default: '0};
      row <= '{default: '0};
      p0 <= '0;
      p1 <= '0;
      sv <= '0;
      cv <= '0;
      sum <= '0;
      out <= '0;
    end else if (bus.iEn) begin
      a <= bus.iData0;
      b <= bus.iData1;
      pp <= ppNext;
      row <= rowNext;
      p0 <= p0Next;
      p1 <= p1Next;
      sv <= p0 ^ p1;
      cv <= (p0 & p1) << 1;
      sum <= sv + cv;
      out <= sum;
    end
`ifdef MULTIPLIER_128B_REG_VALID_EN
  logic [6:0] vld;
  assign bus.oValid = vld[6];
  always_ff @(posedge iClk)
    if (flush) vld <= '0;
    else if (bus.iEn) vld <= {vld[5:0], 1'b1};
`endif
endmodule

// File: tb/tb_multiplier_128b_reg.sv
// tb_multiplier_128b_reg: randomized and directed checks against a product-FIFO model
module tb_multiplier_128b_reg;
  localparam int W = 128;
  logic iClk = 1'b0;
  logic iRst = 1'b1;
  always #5 iClk = ~iClk;
  multiplier_128b_reg_if #(.WIDTH(W)) bus ();
  multiplier_128b_reg #(.WIDTH(W), .LIMB(32)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
  logic [2*W-1:0] want_q [7];
  logic vwant [7];
  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] frozen;
  logic [W-1:0] ones;
  logic [2*W-1:0] ones_sq;
  function automatic logic [2*W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xx, yy;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    return xx * yy;
  endfunction
  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask
  task automatic step(input logic rst, input logic clr, input logic en, input logic [W-1:0] x, input logic [W-1:0] y);
    iRst = rst;
    bus.iClr = clr;
    bus.iEn = en;
    bus.iData0 = x;
    bus.iData1 = y;
    @(posedge iClk);
    if (rst || clr) begin
      for (int i = 0; i < 7; i++) begin
        want_q[i] = '0;
        vwant[i] = 1'b0;
      end
    end else if (en) begin
      for (int i = 6; i > 0; i--) begin
        want_q[i] = want_q[i-1];
        vwant[i] = vwant[i-1];
      end
      want_q[0] = mul(x, y);
      vwant[0] = 1'b1;
    end
    #1;
    check("model", bus.oData, want_q[6]);
`ifdef MULTIPLIER_128B_REG_VALID_EN
    check("valid", {255'b0, bus.oValid}, {255'b0, vwant[6]});
`endif
  endtask
  initial begin
    ones = '1;
    ones_sq = {{127{1'b1}}, 1'b0, {127{1'b0}}, 1'b1};
    step(1, 0, 1, rnd(), rnd());
    step(1, 0, 1, rnd(), rnd());
    check("reset", bus.oData, '0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 1, 128'd3, 128'd5);
      check(k < 6 ? "prefill" : "three_five", bus.oData, k < 6 ? 256'd0 : 256'd15);
    end
    step(0, 0, 1, ones, ones);
    for (int k = 0; k < 6; k++) step(0, 0, 1, rnd(), rnd());
    check("all_ones", bus.oData, ones_sq);
    step(0, 0, 1, '0, rnd());
    for (int k = 0; k < 6; k++) step(0, 0, 1, rnd(), '0);
    check("zero_times_x", bus.oData, '0);
    for (int k = 0; k < 110; k++) step(0, 0, 1, rnd(), rnd());
    frozen = want_q[6];
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, rnd(), rnd());
      check("stall_hold", bus.oData, frozen);
    end
    for (int k = 0; k < 20; k++) step(0, 0, 1, rnd(), rnd());
    step(0, 1, 0, rnd(), rnd());
    check("clr_zero", bus.oData, '0);
    for (int k = 0; k < 7; k++) step(0, 0, 1, rnd(), rnd());
    for (int k = 0; k < 10; k++) step(0, 0, 1, rnd(), rnd());
    step(1, 0, 1, rnd(), rnd());
    check("rst_zero", bus.oData, '0);
    for (int k = 0; k < 10; k++) step(0, 0, 1, rnd(), rnd());
    step(1, 1, 1, rnd(), rnd());
    check("rst_clr_en", bus.oData, '0);
    step(0, 0, 1, 128'd7, 128'd9);
    for (int k = 0; k < 6; k++) step(0, 0, k % 2 == 0, rnd(), rnd());
    for (int k = 0; k < 3; k++) step(0, 0, 1, rnd(), rnd());
    for (int k = 0; k < 30; k++) step(0, 0, $urandom_range(0, 3) != 0, rnd(), rnd());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
